// File: rtl/hazard_stall_controller.sv
// Pipeline hazard/stall sequencer: load-use, branch-in-ID operand and multi-cycle mul/div stalls.
// Outputs are combinational from state/cnt/inputs. Optional stall-cycle counter under HAZARD_PERF_CNT_EN.
module hazard_stall_controller #(
    parameter int MUL_LATENCY = 3,
    parameter int DIV_LATENCY = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_address_id_i,
    input  logic [4:0]  rs2_address_id_i,
    input  logic [4:0]  rs3_address_id_i,
    input  logic        rs1_used_id_i,
    input  logic        rs2_used_id_i,
    input  logic        rs3_used_id_i,
    input  logic        branch_id_i,
    input  logic        branch_taken_id_i,
    input  logic        rd_we_ex_i,
    input  logic [4:0]  rd_address_ex_i,
    input  logic        mem_to_reg_ex_i,
    input  logic        mem_to_reg_mem_i,
    input  logic [4:0]  rd_address_mem_i,
    input  logic        muldiv_ex_i,
    input  logic        div_ex_i,
    output logic        pc_en_o,
    output logic        if_id_en_o,
    output logic        id_ex_en_o,
    output logic        if_id_flush_o,
    output logic        id_ex_flush_o,
    output logic        ex_mem_flush_o,
    output logic        muldiv_busy_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles_o
`endif
);

    localparam int CW = $clog2(DIV_LATENCY) + 1;

    typedef enum logic {
        RUN,
        MD_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [CW-1:0] lat;
    logic          md_start, md_stall;
    logic          load_use, branch_ex, branch_mem, hz_stall;

    function automatic logic match(input logic used, input logic [4:0] rs, input logic [4:0] rd);
        return used && (rs == rd) && (rd != 5'd0);
    endfunction

    always_comb begin
        lat        = div_ex_i ? CW'(DIV_LATENCY) : CW'(MUL_LATENCY);
        md_start   = (state_q == RUN) && muldiv_ex_i && (lat > CW'(1));
        md_stall   = md_start || ((state_q == MD_WAIT) && (cnt_q != '0));

        load_use   = mem_to_reg_ex_i && rd_we_ex_i &&
                     (match(rs1_used_id_i, rs1_address_id_i, rd_address_ex_i) ||
                      match(rs2_used_id_i, rs2_address_id_i, rd_address_ex_i) ||
                      match(rs3_used_id_i, rs3_address_id_i, rd_address_ex_i));
        branch_ex  = branch_id_i && rd_we_ex_i &&
                     (match(rs1_used_id_i, rs1_address_id_i, rd_address_ex_i) ||
                      match(rs2_used_id_i, rs2_address_id_i, rd_address_ex_i));
        branch_mem = branch_id_i && mem_to_reg_mem_i &&
                     (match(rs1_used_id_i, rs1_address_id_i, rd_address_mem_i) ||
                      match(rs2_used_id_i, rs2_address_id_i, rd_address_mem_i));
        hz_stall   = load_use || branch_ex || branch_mem;
    end

    // Next-state: the counter is loaded with LAT-2 so that, together with the
    // md_start cycle, exactly LAT-1 cycles are stalled before the release cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (rst) begin
            state_d = RUN;
            cnt_d   = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (md_start) begin
                        state_d = MD_WAIT;
                        cnt_d   = lat - CW'(2);
                    end
                end
                MD_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
    end

    always_comb begin
        pc_en_o        = 1'b1;
        if_id_en_o     = 1'b1;
        id_ex_en_o     = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_flush_o = 1'b0;
        muldiv_busy_o  = 1'b0;
        if (rst) begin
            pc_en_o        = 1'b0;
            if_id_en_o     = 1'b0;
            id_ex_en_o     = 1'b0;
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
            ex_mem_flush_o = 1'b1;
        end else if (md_stall) begin
            // Freeze the front end; EX keeps the op, MEM receives bubbles.
            pc_en_o        = 1'b0;
            if_id_en_o     = 1'b0;
            id_ex_en_o     = 1'b0;
            ex_mem_flush_o = 1'b1;
            muldiv_busy_o  = 1'b1;
        end else if (hz_stall) begin
            pc_en_o        = 1'b0;
            if_id_en_o     = 1'b0;
            id_ex_flush_o  = 1'b1;
        end else begin
            if_id_flush_o  = branch_id_i && branch_taken_id_i;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (rst) begin
            stall_cycles_d = '0;
        end else if (!pc_en_o && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles_o = stall_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller with hand-computed expected control vectors.
module tb_hazard_stall_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_address_id_i, rs2_address_id_i, rs3_address_id_i;
    logic        rs1_used_id_i, rs2_used_id_i, rs3_used_id_i;
    logic        branch_id_i, branch_taken_id_i;
    logic        rd_we_ex_i;
    logic [4:0]  rd_address_ex_i;
    logic        mem_to_reg_ex_i, mem_to_reg_mem_i;
    logic [4:0]  rd_address_mem_i;
    logic        muldiv_ex_i, div_ex_i;
    logic        pc_en_o, if_id_en_o, id_ex_en_o;
    logic        if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, muldiv_busy_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_o;
`endif

    int errors = 0;
    int checks = 0;

    // {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_flush, muldiv_busy}
    localparam logic [6:0] V_RST  = 7'b000_111_0;
    localparam logic [6:0] V_RUN  = 7'b111_000_0;
    localparam logic [6:0] V_TKN  = 7'b111_100_0;
    localparam logic [6:0] V_HZ   = 7'b001_010_0;
    localparam logic [6:0] V_MD   = 7'b000_001_1;

    always #5 clk = ~clk;

    hazard_stall_controller #(.MUL_LATENCY(3), .DIV_LATENCY(33)) dut (
        .clk               (clk),
        .rst               (rst),
        .rs1_address_id_i  (rs1_address_id_i),
        .rs2_address_id_i  (rs2_address_id_i),
        .rs3_address_id_i  (rs3_address_id_i),
        .rs1_used_id_i     (rs1_used_id_i),
        .rs2_used_id_i     (rs2_used_id_i),
        .rs3_used_id_i     (rs3_used_id_i),
        .branch_id_i       (branch_id_i),
        .branch_taken_id_i (branch_taken_id_i),
        .rd_we_ex_i        (rd_we_ex_i),
        .rd_address_ex_i   (rd_address_ex_i),
        .mem_to_reg_ex_i   (mem_to_reg_ex_i),
        .mem_to_reg_mem_i  (mem_to_reg_mem_i),
        .rd_address_mem_i  (rd_address_mem_i),
        .muldiv_ex_i       (muldiv_ex_i),
        .div_ex_i          (div_ex_i),
        .pc_en_o           (pc_en_o),
        .if_id_en_o        (if_id_en_o),
        .id_ex_en_o        (id_ex_en_o),
        .if_id_flush_o     (if_id_flush_o),
        .id_ex_flush_o     (id_ex_flush_o),
        .ex_mem_flush_o    (ex_mem_flush_o),
        .muldiv_busy_o     (muldiv_busy_o)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles_o    (stall_cycles_o)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        rs1_address_id_i  = '0; rs2_address_id_i = '0; rs3_address_id_i = '0;
        rs1_used_id_i     = 0;  rs2_used_id_i    = 0;  rs3_used_id_i    = 0;
        branch_id_i       = 0;  branch_taken_id_i = 0;
        rd_we_ex_i        = 0;  rd_address_ex_i  = '0;
        mem_to_reg_ex_i   = 0;  mem_to_reg_mem_i = 0;  rd_address_mem_i = '0;
        muldiv_ex_i       = 0;  div_ex_i         = 0;
    endtask

    // Check outputs mid-cycle, then advance to just after the next rising edge.
    task automatic cyc(input string tag, input logic [6:0] exp);
        @(negedge clk);
        check_eq(tag, {25'd0, pc_en_o, if_id_en_o, id_ex_en_o, if_id_flush_o,
                       id_ex_flush_o, ex_mem_flush_o, muldiv_busy_o}, {25'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        mem_to_reg_ex_i = 1; rd_we_ex_i = 1; rd_address_ex_i = rd;
        rs2_address_id_i = 5; rs2_used_id_i = 1;
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        #1;
        cyc("reset", V_RST);
        cyc("reset2", V_RST);
        rst = 0;
        cyc("idle", V_RUN);

        // Load-use on rs2: one bubble, then the load is in MEM and ID proceeds.
        set_load_use(5'd5);
        cyc("lu_stall", V_HZ);
        clear_inputs();
        rs2_address_id_i = 5; rs2_used_id_i = 1; mem_to_reg_mem_i = 1; rd_address_mem_i = 5;
        cyc("lu_release", V_RUN);
        clear_inputs();
        set_load_use(5'd0);
        cyc("lu_x0", V_RUN);
        clear_inputs();
        mem_to_reg_ex_i = 1; rd_we_ex_i = 1; rd_address_ex_i = 9;
        rs3_address_id_i = 9; rs3_used_id_i = 1;
        cyc("lu_rs3", V_HZ);
        rs3_used_id_i = 0; rs1_address_id_i = 9;
        cyc("lu_rs1_unused", V_RUN);

        // Branch behind a load: load-use, then branch-load-MEM, then taken flush.
        clear_inputs();
        branch_id_i = 1; rs1_address_id_i = 7; rs1_used_id_i = 1;
        mem_to_reg_ex_i = 1; rd_we_ex_i = 1; rd_address_ex_i = 7; branch_taken_id_i = 1;
        cyc("br_chain1", V_HZ);
        mem_to_reg_ex_i = 0; rd_we_ex_i = 0; rd_address_ex_i = 0;
        mem_to_reg_mem_i = 1; rd_address_mem_i = 7;
        cyc("br_chain2", V_HZ);
        mem_to_reg_mem_i = 0; rd_address_mem_i = 0;
        cyc("br_taken", V_TKN);
        clear_inputs();
        cyc("br_after", V_RUN);

        // Branch on an ALU result in EX; a non-branch reader of the same rd is forwarded.
        branch_id_i = 1; rs2_address_id_i = 3; rs2_used_id_i = 1;
        rd_we_ex_i = 1; rd_address_ex_i = 3;
        cyc("br_ex", V_HZ);
        branch_id_i = 0;
        cyc("alu_fwd", V_RUN);
        clear_inputs();
        branch_id_i = 1; rs1_address_id_i = 0; rs1_used_id_i = 1;
        mem_to_reg_mem_i = 1; rd_address_mem_i = 0;
        cyc("br_mem_x0", V_RUN);
        clear_inputs();

        // DIV: 32 stalled cycles then release; div_ex_i toggled mid-wait must be ignored.
        muldiv_ex_i = 1; div_ex_i = 1;
        for (int i = 0; i < 33; i++) begin
            if (i == 1) div_ex_i = 0;
            cyc((i < 32) ? "div_stall" : "div_release", (i < 32) ? V_MD : V_RUN);
        end
        clear_inputs();
        cyc("div_after", V_RUN);

        // Back-to-back MULs: 2 stalls, release, second op restarts immediately.
        muldiv_ex_i = 1;
        for (int i = 0; i < 6; i++) begin
            cyc((i % 3 == 2) ? "mul_release" : "mul_stall", (i % 3 == 2) ? V_RUN : V_MD);
        end
        clear_inputs();

        // md_start outranks load-use and ignores branch_taken; hazard remains at release.
        muldiv_ex_i = 1; set_load_use(5'd5);
        branch_id_i = 1; branch_taken_id_i = 1;
        cyc("prec_md0", V_MD);
        cyc("prec_md1", V_MD);
        cyc("prec_release_hz", V_HZ);
        clear_inputs();

        // Reset during a DIV wait at cnt=10 aborts it.
        muldiv_ex_i = 1; div_ex_i = 1;
        for (int i = 0; i < 22; i++) step();
        rst = 1;
        cyc("rst_mid", V_RST);
        rst = 0; clear_inputs();
        cyc("rst_post", V_RUN);
        cyc("rst_post2", V_RUN);

`ifdef HAZARD_PERF_CNT_EN
        rst = 1;
        step();
        rst = 0;
        set_load_use(5'd5);
        step();
        clear_inputs();
        muldiv_ex_i = 1; div_ex_i = 1;
        for (int i = 0; i < 33; i++) step();
        clear_inputs();
        @(negedge clk);
        check_eq("perf_33", stall_cycles_o, 32'd33);
        force dut.stall_cycles_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cycles_q;
        step();
        muldiv_ex_i = 1;
        for (int i = 0; i < 3; i++) step();
        clear_inputs();
        @(negedge clk);
        check_eq("perf_sat", stall_cycles_o, 32'hFFFF_FFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
